// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for a shared-ALU, shared-memory MIPS datapath.
// It raises illegal-instruction pulses, handles the memory-ready handshake and counts retirements.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             IllegalInstr,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef struct packed {
    logic       pc_write;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_source;
  } ctrl_t;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic             funct_legal;
  logic [2:0]       funct_alu;
  ctrl_t            ctrl;

  // R-type function decode; shared by DECODE legality and EXEC ALU select.
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = AluAdd;
    unique case (funct)
      FnAdd:   funct_alu = AluAdd;
      FnSub:   funct_alu = AluSub;
      FnAnd:   funct_alu = AluAnd;
      FnOr:    funct_alu = AluOr;
      FnSlt:   funct_alu = AluSlt;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (MemReady) state_d = StDecode;
      end
      StDecode: begin
        unique case (opcode)
          OpRType: begin
            if (funct_legal) begin
              state_d = StExec;
            end else begin
              state_d   = StFetch;
              illegal_d = 1'b1;
            end
          end
          OpLw, OpSw:   state_d = StMemAdr;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:          state_d = StJump;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (MemReady) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExec:  state_d = StAluWb;
      StAluWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StBranch, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      StFetch: begin
        ctrl.mem_read    = 1'b1;
        ctrl.alu_src_b   = 2'b01;
        ctrl.alu_control = AluAdd;
        ctrl.ir_write    = MemReady;
        ctrl.pc_write    = MemReady;
      end
      StDecode: begin
        ctrl.alu_src_b   = 2'b11;
        ctrl.alu_control = AluAdd;
      end
      StMemAdr: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = 2'b10;
        ctrl.alu_control = AluAdd;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      StExec: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_control = funct_alu;
      end
      StAluWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_control = AluSub;
        ctrl.pc_source   = 2'b01;
        ctrl.pc_write    = ((opcode == OpBeq) & Zero) | ((opcode == OpBne) & ~Zero);
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      default: ctrl = '0;
    endcase
    // Reset is asynchronous, so in-flight memory requests must drop without waiting for a clock.
    if (reset) ctrl = '0;
  end

  assign PCWrite    = ctrl.pc_write;
  assign IorD       = ctrl.ior_d;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign MemToReg   = ctrl.mem_to_reg;
  assign RegDst     = ctrl.reg_dst;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUControl = ctrl.alu_control;
  assign PCSource   = ctrl.pc_source;

  assign State        = state_q;
  assign IllegalInstr = illegal_q;
  assign InstrCount   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors queue expectations,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control;

  localparam int unsigned CW = 4;

  localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SMemAdr = 4'd2, SMemRd = 4'd3;
  localparam logic [3:0] SMemWb = 4'd4, SMemWr = 4'd5, SExec = 4'd6, SAluWb = 4'd7;
  localparam logic [3:0] SBranch = 4'd8, SJump = 4'd9;

  // {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSource}
  localparam logic [16:0] CNone      = 17'b0_0_0_0_0_0_0_0_0_00_000_00;
  localparam logic [16:0] CFetchRdy  = 17'b1_0_1_0_1_0_0_0_0_01_010_00;
  localparam logic [16:0] CFetchWait = 17'b0_0_1_0_0_0_0_0_0_01_010_00;
  localparam logic [16:0] CDecode    = 17'b0_0_0_0_0_0_0_0_0_11_010_00;
  localparam logic [16:0] CMemAdr    = 17'b0_0_0_0_0_0_0_0_1_10_010_00;
  localparam logic [16:0] CMemRd     = 17'b0_1_1_0_0_0_0_0_0_00_000_00;
  localparam logic [16:0] CMemWb     = 17'b0_0_0_0_0_1_0_1_0_00_000_00;
  localparam logic [16:0] CMemWr     = 17'b0_1_0_1_0_0_0_0_0_00_000_00;
  localparam logic [16:0] CAluWb     = 17'b0_0_0_0_0_0_1_1_0_00_000_00;
  localparam logic [16:0] CBrTaken   = 17'b1_0_0_0_0_0_0_0_1_00_110_01;
  localparam logic [16:0] CBrNot     = 17'b0_0_0_0_0_0_0_0_1_00_110_01;
  localparam logic [16:0] CJump      = 17'b1_0_0_0_0_0_0_0_0_00_000_10;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpBne = 6'b000101, OpJ = 6'b000010;
  localparam logic [5:0] OpBad = 6'b111111;

  typedef struct packed {
    int          id;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic        ill;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk, reset, Zero, MemReady;
  logic [5:0]    opcode, funct;
  logic          PCWrite, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]    ALUSrcB, PCSource;
  logic [2:0]    ALUControl;
  logic [3:0]    State;
  logic          IllegalInstr;
  logic [CW-1:0] InstrCount;
  logic [16:0]   ctrl_act;

  exp_t          sb[$];
  logic [CW-1:0] cnt_model;
  int            step_id;
  int            n_checks;
  int            n_fail;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSource(PCSource), .State(State), .IllegalInstr(IllegalInstr), .InstrCount(InstrCount)
  );

  assign ctrl_act = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite,
                     ALUSrcA, ALUSrcB, ALUControl, PCSource};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected vector per clock, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (State !== e.st || ctrl_act !== e.ctrl || IllegalInstr !== e.ill ||
            InstrCount !== e.cnt) begin
          n_fail++;
          $display("FAIL step%0d: got st=%0d ctrl=%b ill=%b cnt=%0d, expected st=%0d ctrl=%b ill=%b cnt=%0d",
                   e.id, State, ctrl_act, IllegalInstr, InstrCount, e.st, e.ctrl, e.ill, e.cnt);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input logic [3:0] st,
                      input logic [16:0] c, input logic ill, input logic ret);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    opcode   = op;
    funct    = fn;
    Zero     = z;
    MemReady = mr;
    if (rst) cnt_model = '0;
    step_id++;
    e.id   = step_id;
    e.st   = st;
    e.ctrl = c;
    e.ill  = ill;
    e.cnt  = cnt_model;
    sb.push_back(e);
    if (ret && !rst) cnt_model = cnt_model + 1'b1;
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input logic ill);
    step(1'b0, op, fn, 1'b0, 1'b1, SFetch, CFetchRdy, ill, 1'b0);
    step(1'b0, op, fn, 1'b0, 1'b0, SDecode, CDecode, 1'b0, 1'b0);
  endtask

  logic [5:0] r_fn [4];
  logic [2:0] r_alu [4];

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; Zero = 1'b0; MemReady = 1'b1;
    cnt_model = '0; step_id = 0; n_checks = 0; n_fail = 0;
    r_fn[0] = 6'b100010; r_alu[0] = 3'b110;
    r_fn[1] = 6'b100100; r_alu[1] = 3'b000;
    r_fn[2] = 6'b100101; r_alu[2] = 3'b001;
    r_fn[3] = 6'b101010; r_alu[3] = 3'b111;

    // Reset: everything low even with MemReady high.
    step(1'b1, OpR, 6'b100000, 1'b0, 1'b1, SFetch, CNone, 1'b0, 1'b0);
    step(1'b1, OpR, 6'b100000, 1'b0, 1'b1, SFetch, CNone, 1'b0, 1'b0);

    // add
    fetch_decode(OpR, 6'b100000, 1'b0);
    step(1'b0, OpR, 6'b100000, 1'b0, 1'b1, SExec, 17'b0_0_0_0_0_0_0_0_1_00_010_00, 1'b0, 1'b0);
    step(1'b0, OpR, 6'b100000, 1'b0, 1'b1, SAluWb, CAluWb, 1'b0, 1'b1);

    // sub / and / or / slt
    for (int i = 0; i < 4; i++) begin
      fetch_decode(OpR, r_fn[i], 1'b0);
      step(1'b0, OpR, r_fn[i], 1'b0, 1'b0, SExec, {9'b0_0_0_0_0_0_0_0_1, 2'b00, r_alu[i], 2'b00},
           1'b0, 1'b0);
      step(1'b0, OpR, r_fn[i], 1'b0, 1'b0, SAluWb, CAluWb, 1'b0, 1'b1);
    end

    // lw with a fetch stall and two MEMRD wait cycles
    step(1'b0, OpLw, 6'b0, 1'b0, 1'b0, SFetch, CFetchWait, 1'b0, 1'b0);
    fetch_decode(OpLw, 6'b0, 1'b0);
    step(1'b0, OpLw, 6'b0, 1'b0, 1'b1, SMemAdr, CMemAdr, 1'b0, 1'b0);
    step(1'b0, OpLw, 6'b0, 1'b0, 1'b0, SMemRd, CMemRd, 1'b0, 1'b0);
    step(1'b0, OpLw, 6'b0, 1'b0, 1'b0, SMemRd, CMemRd, 1'b0, 1'b0);
    step(1'b0, OpLw, 6'b0, 1'b0, 1'b1, SMemRd, CMemRd, 1'b0, 1'b0);
    step(1'b0, OpLw, 6'b0, 1'b0, 1'b0, SMemWb, CMemWb, 1'b0, 1'b1);

    // sw with one MEMWR wait cycle; retires on the ready cycle
    fetch_decode(OpSw, 6'b0, 1'b0);
    step(1'b0, OpSw, 6'b0, 1'b0, 1'b0, SMemAdr, CMemAdr, 1'b0, 1'b0);
    step(1'b0, OpSw, 6'b0, 1'b0, 1'b0, SMemWr, CMemWr, 1'b0, 1'b0);
    step(1'b0, OpSw, 6'b0, 1'b0, 1'b1, SMemWr, CMemWr, 1'b0, 1'b1);

    // Branches: beq/bne with Zero high and low
    fetch_decode(OpBeq, 6'b0, 1'b0);
    step(1'b0, OpBeq, 6'b0, 1'b1, 1'b1, SBranch, CBrTaken, 1'b0, 1'b1);
    fetch_decode(OpBne, 6'b0, 1'b0);
    step(1'b0, OpBne, 6'b0, 1'b1, 1'b1, SBranch, CBrNot, 1'b0, 1'b1);
    fetch_decode(OpBeq, 6'b0, 1'b0);
    step(1'b0, OpBeq, 6'b0, 1'b0, 1'b1, SBranch, CBrNot, 1'b0, 1'b1);
    fetch_decode(OpBne, 6'b0, 1'b0);
    step(1'b0, OpBne, 6'b0, 1'b0, 1'b1, SBranch, CBrTaken, 1'b0, 1'b1);

    // Illegal opcode, then R-type with bad funct; each pulses IllegalInstr in the next FETCH
    fetch_decode(OpBad, 6'b0, 1'b0);
    fetch_decode(OpR, 6'b000111, 1'b1);
    step(1'b0, OpJ, 6'b0, 1'b0, 1'b0, SFetch, CFetchWait, 1'b1, 1'b0);
    step(1'b0, OpJ, 6'b0, 1'b0, 1'b0, SFetch, CFetchWait, 1'b0, 1'b0);

    // 16 jumps: counter wraps through zero
    for (int j = 0; j < 16; j++) begin
      fetch_decode(OpJ, 6'b0, 1'b0);
      step(1'b0, OpJ, 6'b0, 1'b0, 1'b1, SJump, CJump, 1'b0, 1'b1);
    end

    // Reset in the middle of a stalled store
    fetch_decode(OpSw, 6'b0, 1'b0);
    step(1'b0, OpSw, 6'b0, 1'b0, 1'b1, SMemAdr, CMemAdr, 1'b0, 1'b0);
    step(1'b0, OpSw, 6'b0, 1'b0, 1'b0, SMemWr, CMemWr, 1'b0, 1'b0);
    step(1'b1, OpSw, 6'b0, 1'b0, 1'b0, SFetch, CNone, 1'b0, 1'b0);
    step(1'b0, OpSw, 6'b0, 1'b0, 1'b1, SFetch, CFetchRdy, 1'b0, 1'b0);
    step(1'b0, OpSw, 6'b0, 1'b0, 1'b1, SDecode, CDecode, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
